// File: rtl/lsu_mem_master_pkg.sv
// Shared encodings and helpers for the load/store memory master.
package lsu_mem_master_pkg;

    localparam int unsigned XLEN = 32;

    // funct3 load/store size encodings
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;

    // Unshifted byte-lane masks
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Registered copy of the accepted request
    typedef struct packed {
        logic [2:0] op;
        logic       store;
        logic [1:0] off;
    } lsu_req_t;

    // Byte-lane mask for an access; unknown op codes behave as word
    function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] off);
        case (op)
            OP_B, OP_BU: lane_mask = 4'(MASK_B << off);
            OP_H, OP_HU: lane_mask = 4'(MASK_H << off);
            default:     lane_mask = MASK_W;
        endcase
    endfunction

    // Halfwords need even addresses, words need 4-byte alignment
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            OP_B, OP_BU: is_misaligned = 1'b0;
            OP_H, OP_HU: is_misaligned = off[0];
            default:     is_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_master_load_align.sv
// Moves the addressed lanes of a read word down to bit 0 and extends them.
module lsu_load_align
    import lsu_mem_master_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data_c
);

    logic [XLEN-1:0] shifted;

    // Right-shift by byte offset, then sign/zero extend by op
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (op)
            OP_B:    data_c = {{24{shifted[7]}}, shifted[7:0]};
            OP_BU:   data_c = {24'h0, shifted[7:0]};
            OP_H:    data_c = {{16{shifted[15]}}, shifted[15:0]};
            OP_HU:   data_c = {16'h0, shifted[15:0]};
            default: data_c = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the execute stage and the data-memory port.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic                  req_store,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_misalign,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [7:0]            mem_rmask,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]            mem_wmask,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    localparam int unsigned CNT_W = 4;

    logic [1:0]            state_q, state_d;
    lsu_req_t              req_q, req_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  req_ready_d, rsp_valid_d, rsp_misalign_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  mem_ren_d, mem_wen_d;
    logic [ADDR_WIDTH-1:0] mem_raddr_d, mem_waddr_d;
    logic [7:0]            mem_rmask_d, mem_wmask_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;

    logic [ADDR_WIDTH-1:0] word_addr_c;
    logic [3:0]            mask_c;
    logic                  misalign_c;
    logic [DATA_WIDTH-1:0] load_data_c;

    assign word_addr_c = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign mask_c      = lane_mask(req_op, req_addr[1:0]);
    assign misalign_c  = is_misaligned(req_op, req_addr[1:0]);

    lsu_load_align u_load_align (
        .op     (req_q.op),
        .off    (req_q.off),
        .rdata  (mem_rdata),
        .data_c (load_data_c)
    );

    // State, captured request and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            cnt_q        <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_misalign <= 1'b0;
            mem_ren      <= 1'b0;
            mem_raddr    <= '0;
            mem_rmask    <= '0;
            mem_wen      <= 1'b0;
            mem_waddr    <= '0;
            mem_wmask    <= '0;
            mem_wdata    <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            req_ready    <= req_ready_d;
            rsp_valid    <= rsp_valid_d;
            rsp_rdata    <= rsp_rdata_d;
            rsp_misalign <= rsp_misalign_d;
            mem_ren      <= mem_ren_d;
            mem_raddr    <= mem_raddr_d;
            mem_rmask    <= mem_rmask_d;
            mem_wen      <= mem_wen_d;
            mem_waddr    <= mem_waddr_d;
            mem_wmask    <= mem_wmask_d;
            mem_wdata    <= mem_wdata_d;
        end
    end

    // Next state and next output values; stores reuse RD_WAIT as their single write cycle
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        cnt_d          = cnt_q;
        req_ready_d    = req_ready;
        rsp_valid_d    = rsp_valid;
        rsp_rdata_d    = rsp_rdata;
        rsp_misalign_d = rsp_misalign;
        mem_ren_d      = mem_ren;
        mem_raddr_d    = mem_raddr;
        mem_rmask_d    = mem_rmask;
        mem_wen_d      = mem_wen;
        mem_waddr_d    = mem_waddr;
        mem_wmask_d    = mem_wmask;
        mem_wdata_d    = mem_wdata;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    req_d.op    = req_op;
                    req_d.store = req_store;
                    req_d.off   = req_addr[1:0];
                    req_ready_d = 1'b0;
                    if (misalign_c) begin
                        state_d        = ST_RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_misalign_d = 1'b1;
                        rsp_rdata_d    = '0;
                    end else if (req_store) begin
                        state_d     = ST_RD_WAIT;
                        cnt_d       = '0;
                        mem_wen_d   = 1'b1;
                        mem_waddr_d = word_addr_c;
                        mem_wmask_d = {4'b0000, mask_c};
                        mem_wdata_d = req_wdata << {req_addr[1:0], 3'b000};
                    end else begin
                        state_d     = ST_RD_WAIT;
                        cnt_d       = CNT_W'(RD_LATENCY - 1);
                        mem_ren_d   = 1'b1;
                        mem_raddr_d = word_addr_c;
                        mem_rmask_d = {4'b0000, mask_c};
                    end
                end
            end
            ST_RD_WAIT: begin
                if (req_q.store) begin
                    state_d        = ST_RESP;
                    mem_wen_d      = 1'b0;
                    mem_waddr_d    = '0;
                    mem_wmask_d    = '0;
                    mem_wdata_d    = '0;
                    rsp_valid_d    = 1'b1;
                    rsp_rdata_d    = '0;
                    rsp_misalign_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d        = ST_RESP;
                    mem_ren_d      = 1'b0;
                    mem_raddr_d    = '0;
                    mem_rmask_d    = '0;
                    rsp_valid_d    = 1'b1;
                    rsp_rdata_d    = load_data_c;
                    rsp_misalign_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d        = ST_IDLE;
                    rsp_valid_d    = 1'b0;
                    rsp_rdata_d    = '0;
                    rsp_misalign_d = 1'b0;
                    req_ready_d    = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master at read latency 1 and 3.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_op;
    logic        req_store;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic        rsp_ready;

    logic        req_valid1, req_ready1, rsp_valid1, rsp_misalign1, mem_ren1, mem_wen1;
    logic [31:0] rsp_rdata1, mem_raddr1, mem_waddr1, mem_wdata1;
    logic [7:0]  mem_rmask1, mem_wmask1;

    logic        req_valid3, req_ready3, rsp_valid3, rsp_misalign3, mem_ren3, mem_wen3;
    logic [31:0] rsp_rdata3, mem_raddr3, mem_waddr3, mem_wdata3;
    logic [7:0]  mem_rmask3, mem_wmask3;

    int n_chk  = 0;
    int n_fail = 0;
    int ren_cnt;
    logic got;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op),
        .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1),
        .rsp_misalign(rsp_misalign1),
        .mem_ren(mem_ren1), .mem_raddr(mem_raddr1), .mem_rmask(mem_rmask1),
        .mem_rdata(mem_rdata),
        .mem_wen(mem_wen1), .mem_waddr(mem_waddr1), .mem_wmask(mem_wmask1),
        .mem_wdata(mem_wdata1)
    );

    lsu_mem_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op),
        .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3),
        .rsp_misalign(rsp_misalign3),
        .mem_ren(mem_ren3), .mem_raddr(mem_raddr3), .mem_rmask(mem_rmask3),
        .mem_rdata(mem_rdata),
        .mem_wen(mem_wen3), .mem_waddr(mem_waddr3), .mem_wmask(mem_wmask3),
        .mem_wdata(mem_wdata3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request to dut1 for a single accepting cycle
    task automatic issue1(input logic [2:0] op, input logic st, input logic [31:0] a, input logic [31:0] wd);
        req_op = op; req_store = st; req_addr = a; req_wdata = wd;
        req_valid1 = 1'b1;
        step();
        req_valid1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid1 = 1'b0; req_valid3 = 1'b0;
        req_op = 3'b010; req_store = 1'b0; req_addr = '0; req_wdata = '0;
        mem_rdata = '0; rsp_ready = 1'b1;
        step(); step();

        chk("rst_req_ready", 32'(req_ready1), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
        chk("rst_ren",       32'(mem_ren1),   32'd0);
        chk("rst_wen",       32'(mem_wen1),   32'd0);
        chk("rst_wdata",     mem_wdata1,      32'd0);
        rst = 1'b0;
        step();

        // sw aligned
        issue1(3'b010, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF);
        chk("sw_wen",       32'(mem_wen1),  32'd1);
        chk("sw_ren",       32'(mem_ren1),  32'd0);
        chk("sw_waddr",     mem_waddr1,     32'h8000_0004);
        chk("sw_wmask",     32'(mem_wmask1), 32'h0F);
        chk("sw_wdata",     mem_wdata1,     32'hDEAD_BEEF);
        chk("sw_busy",      32'(req_ready1), 32'd0);
        chk("sw_no_rsp",    32'(rsp_valid1), 32'd0);
        step();
        chk("sw_wen_drop",  32'(mem_wen1),  32'd0);
        chk("sw_rsp_valid", 32'(rsp_valid1), 32'd1);
        chk("sw_rsp_rdata", rsp_rdata1,     32'd0);
        chk("sw_rsp_mis",   32'(rsp_misalign1), 32'd0);
        step();
        chk("sw_done_valid", 32'(rsp_valid1), 32'd0);
        chk("sw_done_ready", 32'(req_ready1), 32'd1);

        // sb to top lane
        issue1(3'b000, 1'b1, 32'h8000_0003, 32'h0000_00A5);
        chk("sb_wen",   32'(mem_wen1),   32'd1);
        chk("sb_waddr", mem_waddr1,      32'h8000_0000);
        chk("sb_wmask", 32'(mem_wmask1), 32'h08);
        chk("sb_wdata", mem_wdata1,      32'hA500_0000);
        step();
        chk("sb_rsp", 32'(rsp_valid1), 32'd1);
        step();

        // sh to upper half
        issue1(3'b001, 1'b1, 32'h8000_0002, 32'h1234_BEEF);
        chk("sh_wmask", 32'(mem_wmask1), 32'h0C);
        chk("sh_wdata", mem_wdata1,      32'hBEEF_0000);
        step(); step();

        // lb sign extension from lane 2
        mem_rdata = 32'h1280_3456;
        issue1(3'b000, 1'b0, 32'h8000_0002, 32'h0);
        chk("lb_ren",   32'(mem_ren1),   32'd1);
        chk("lb_wen",   32'(mem_wen1),   32'd0);
        chk("lb_raddr", mem_raddr1,      32'h8000_0000);
        chk("lb_rmask", 32'(mem_rmask1), 32'h04);
        step();
        chk("lb_ren_drop", 32'(mem_ren1),  32'd0);
        chk("lb_rsp",      32'(rsp_valid1), 32'd1);
        chk("lb_rdata",    rsp_rdata1,     32'hFFFF_FF80);
        step();

        // lbu zero extension
        issue1(3'b100, 1'b0, 32'h8000_0002, 32'h0);
        step();
        chk("lbu_rdata", rsp_rdata1, 32'h0000_0080);
        step();

        // lh from upper half (positive) and lhu
        issue1(3'b001, 1'b0, 32'h8000_0002, 32'h0);
        chk("lh_rmask", 32'(mem_rmask1), 32'h0C);
        step();
        chk("lh_rdata", rsp_rdata1, 32'h0000_1280);
        step();
        mem_rdata = 32'h8001_0000;
        issue1(3'b001, 1'b0, 32'h8000_0002, 32'h0);
        step();
        chk("lh_neg_rdata", rsp_rdata1, 32'hFFFF_8001);
        step();
        issue1(3'b101, 1'b0, 32'h8000_0002, 32'h0);
        step();
        chk("lhu_rdata", rsp_rdata1, 32'h0000_8001);
        step();

        // misaligned lh: straight to response, no memory activity
        mem_rdata = 32'h1280_3456;
        issue1(3'b001, 1'b0, 32'h8000_0001, 32'h0);
        chk("mis_ren",   32'(mem_ren1),      32'd0);
        chk("mis_wen",   32'(mem_wen1),      32'd0);
        chk("mis_rsp",   32'(rsp_valid1),    32'd1);
        chk("mis_flag",  32'(rsp_misalign1), 32'd1);
        chk("mis_rdata", rsp_rdata1,         32'd0);
        step();
        chk("mis_ready", 32'(req_ready1), 32'd1);

        // following lw completes normally
        issue1(3'b010, 1'b0, 32'h8000_0000, 32'h0);
        chk("lw_ren",   32'(mem_ren1),   32'd1);
        chk("lw_rmask", 32'(mem_rmask1), 32'h0F);
        step();
        chk("lw_rdata", rsp_rdata1,         32'h1280_3456);
        chk("lw_mis",   32'(rsp_misalign1), 32'd0);
        step();

        // RD_LATENCY = 3 load with response backpressure
        rsp_ready = 1'b0;
        mem_rdata = '0;
        req_op = 3'b010; req_store = 1'b0; req_addr = 32'h8000_0010;
        req_valid3 = 1'b1;
        step();
        req_valid3 = 1'b0;
        chk("l3_raddr", mem_raddr3,      32'h8000_0010);
        chk("l3_rmask", 32'(mem_rmask3), 32'h0F);
        ren_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid3) begin
                got = 1'b1;
                break;
            end
            if (mem_ren3) ren_cnt++;
            mem_rdata = (ren_cnt == 3) ? 32'h0BAD_F00D : 32'h0;
            step();
        end
        chk("l3_rsp_timeout", 32'(got),      32'd1);
        chk("l3_ren_cycles",  32'(ren_cnt),  32'd3);
        chk("l3_ren_drop",    32'(mem_ren3), 32'd0);
        chk("l3_rdata",       rsp_rdata3,    32'h0BAD_F00D);
        mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            chk("l3_hold_valid", 32'(rsp_valid3), 32'd1);
            chk("l3_hold_rdata", rsp_rdata3,      32'h0BAD_F00D);
            chk("l3_hold_ready", 32'(req_ready3), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("l3_done_valid", 32'(rsp_valid3), 32'd0);
        chk("l3_done_ready", 32'(req_ready3), 32'd1);

        // reset during RD_WAIT abandons the load
        req_addr = 32'h8000_0020;
        req_valid3 = 1'b1;
        step();
        req_valid3 = 1'b0;
        chk("rw_ren_before", 32'(mem_ren3), 32'd1);
        step();
        #2 rst = 1'b1;
        #1;
        chk("rw_ren_async",   32'(mem_ren3),   32'd0);
        chk("rw_ready_async", 32'(req_ready3), 32'd1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rw_no_rsp", 32'(rsp_valid3), 32'd0);
            chk("rw_ready",  32'(req_ready3), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
